// File: rtl/axi_chan_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_chan_stream_pkg
//  Brief    : Shared constants and types for the AXI channel stream mux.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_chan_stream_pkg;

    // Default channel ordering for a full AXI4 tap set
    localparam int CH_AR = 0;
    localparam int CH_AW = 1;
    localparam int CH_R  = 2;
    localparam int CH_W  = 3;
    localparam int CH_B  = 4;

    localparam int NUM_STD_CH = CH_B + 1;
    localparam int TDEST_W    = 3;

    typedef enum logic [0:0] {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Per-beat sideband. The payload width is a module parameter, so the top
    // wraps this together with the data into its own beat struct.
    typedef struct packed {
        logic last;
        logic drop;
    } beat_tag_t;

endpackage

`default_nettype wire

// File: rtl/chan_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : chan_fifo
//  Brief    : Small synchronous FIFO with push/pop/flush and full/empty flags.
//             A push while full is accepted only if a pop happens in the same
//             cycle. Flush has priority over push and pop.
//  Revision : 1.0 - initial release
// ============================================================================
module chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int             c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_full_cnt = DEPTH[c_ptr_w:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_cnt);
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/axi_chan_stream_mux.sv
`default_nettype none
// ============================================================================
//  Module   : axi_chan_stream_mux
//  Brief    : Buffers N monitored AXI channel taps in per-channel FIFOs and
//             merges them onto one AXI4-Stream master with round-robin or
//             fixed-priority arbitration, optional packet locking, source
//             tagging on tdest and saturating per-channel drop counters.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_chan_stream_mux
    import axi_chan_stream_pkg::*;
#(
    parameter int NUM_CH     = NUM_STD_CH,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = 0,
    parameter int PKT_LOCK   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_CH-1:0]         ch_fire,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic [NUM_CH-1:0]         ch_last,
    input  logic [NUM_CH-1:0]         ch_enable,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [TDEST_W-1:0]        m_axis_tdest,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic [NUM_CH*CNT_W-1:0]   drop_count
);

    localparam int        c_idx_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam arb_mode_e c_arb_mode = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        beat_tag_t         tag;
    } beat_t;

    localparam int c_beat_w = $bits(beat_t);

    logic [NUM_CH-1:0]  w_push;
    logic [NUM_CH-1:0]  w_pop;
    logic [NUM_CH-1:0]  w_full;
    logic [NUM_CH-1:0]  w_empty;
    logic [NUM_CH-1:0]  w_drop;
    logic [NUM_CH-1:0]  w_cand;
    logic [NUM_CH-1:0]  w_drop_flag;
    beat_t              w_rd_beat [NUM_CH];
    beat_t              w_sel;

    logic               w_load_en;
    logic               w_grant_valid;
    logic [c_idx_w-1:0] w_grant_idx;
    logic [c_idx_w-1:0] w_scan_idx;

    logic               r_tvalid;
    logic [DATA_W-1:0]  r_tdata;
    logic [TDEST_W-1:0] r_tdest;
    logic               r_tlast;
    logic               r_tuser;
    logic               r_lock;
    logic [c_idx_w-1:0] r_lock_idx;
    logic [c_idx_w-1:0] r_rr_ptr;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        beat_t            w_wr_beat;
        logic             r_flag;
        logic [CNT_W-1:0] r_cnt;

        // Enable low is the flush; capture only counts while enabled
        assign w_push[gi]         = ch_fire[gi] & ch_enable[gi];
        assign w_drop[gi]         = w_push[gi] & w_full[gi] & ~w_pop[gi];
        assign w_cand[gi]         = ~w_empty[gi] & ch_enable[gi];
        assign w_wr_beat.data     = ch_data[gi*DATA_W +: DATA_W];
        assign w_wr_beat.tag.last = ch_last[gi];
        assign w_wr_beat.tag.drop = r_flag;
        assign w_drop_flag[gi]    = r_flag;
        assign drop_count[gi*CNT_W +: CNT_W] = r_cnt;

        chan_fifo #(
            .WIDTH (c_beat_w),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (aclk),
            .rst_n   (aresetn),
            .i_push  (w_push[gi]),
            .i_pop   (w_pop[gi]),
            .i_flush (~ch_enable[gi]),
            .i_wdata (w_wr_beat),
            .o_rdata (w_rd_beat[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi])
        );

        // Sticky drop flag and saturating drop counter; an accepted push clears the flag
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_flag <= 1'b0;
                r_cnt  <= '0;
            end else if (w_drop[gi]) begin
                r_flag <= 1'b1;
                if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end else if (w_push[gi]) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign w_load_en = ~r_tvalid | m_axis_tready;
    assign w_sel     = w_rd_beat[w_grant_idx];

    // Grant selection: a held lock pins the grant (stalling if that FIFO is empty),
    // otherwise scan from the lowest index or from one past the last grant
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = '0;
        if (r_lock) begin
            if (w_cand[r_lock_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = r_lock_idx;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (c_arb_mode == ARB_FIXED) begin
                    w_scan_idx = c_idx_w'(k);
                end else begin
                    w_scan_idx = c_idx_w'((int'(r_rr_ptr) + k + 1) % NUM_CH);
                end
                if (!w_grant_valid && w_cand[w_scan_idx]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = w_scan_idx;
                end
            end
        end
    end

    // Pop the granted FIFO whenever its head moves into the output register
    always_comb begin
        w_pop = '0;
        if (w_load_en && w_grant_valid) w_pop[w_grant_idx] = 1'b1;
    end

    // Output register, round-robin pointer and packet lock
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tdest    <= '0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= c_idx_w'(NUM_CH - 1);
        end else begin
            if (w_load_en) begin
                r_tvalid <= w_grant_valid;
                if (w_grant_valid) begin
                    r_tdata  <= w_sel.data;
                    r_tdest  <= TDEST_W'(w_grant_idx);
                    r_tlast  <= w_sel.tag.last;
                    r_tuser  <= w_sel.tag.drop;
                    r_rr_ptr <= w_grant_idx;
                    if (PKT_LOCK != 0) begin
                        r_lock     <= ~w_sel.tag.last;
                        r_lock_idx <= w_grant_idx;
                    end
                end
            end
            // A disabled lock owner cannot be granted, so this never races a load
            if (r_lock && !ch_enable[r_lock_idx]) r_lock <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tdest  = r_tdest;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;

endmodule

`default_nettype wire

// File: tb/tb_axi_chan_stream_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_chan_stream_mux
//  Brief    : Directed self-checking bench for axi_chan_stream_mux. A default
//             instance (round-robin, packet lock) and a fixed-priority,
//             unlocked instance share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_chan_stream_mux;
    import axi_chan_stream_pkg::*;

    localparam int NCH = 5;
    localparam int DW  = 64;
    localparam int CW  = 16;

    typedef struct packed {
        int          cyc;
        logic [2:0]  dest;
        logic [63:0] data;
        logic        last;
        logic        user;
    } obs_t;

    logic              aclk;
    logic              aresetn;
    logic [NCH-1:0]    ch_fire;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_last;
    logic [NCH-1:0]    ch_enable;
    logic              m_axis_tready;

    logic              m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic [DW-1:0]     m_axis_tdata;
    logic [2:0]        m_axis_tdest;
    logic [NCH*CW-1:0] drop_count;

    logic              f_tvalid, f_tlast, f_tuser;
    logic [DW-1:0]     f_tdata;
    logic [2:0]        f_tdest;
    logic [NCH*CW-1:0] f_drop_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;
    obs_t q_main[$];
    obs_t q_fix[$];

    axi_chan_stream_mux #(
        .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(4), .ARB_MODE(0), .PKT_LOCK(1), .CNT_W(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .ch_fire(ch_fire), .ch_data(ch_data),
        .ch_last(ch_last), .ch_enable(ch_enable), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tdest(m_axis_tdest), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .drop_count(drop_count)
    );

    axi_chan_stream_mux #(
        .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(4), .ARB_MODE(1), .PKT_LOCK(0), .CNT_W(CW)
    ) dut_fix (
        .aclk(aclk), .aresetn(aresetn), .ch_fire(ch_fire), .ch_data(ch_data),
        .ch_last(ch_last), .ch_enable(ch_enable), .m_axis_tvalid(f_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(f_tdata),
        .m_axis_tdest(f_tdest), .m_axis_tlast(f_tlast),
        .m_axis_tuser(f_tuser), .drop_count(f_drop_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    // Record every beat that will transfer at the coming rising edge
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready)
            q_main.push_back('{cyc_cnt, m_axis_tdest, m_axis_tdata, m_axis_tlast, m_axis_tuser});
        if (aresetn && f_tvalid && m_axis_tready)
            q_fix.push_back('{cyc_cnt, f_tdest, f_tdata, f_tlast, f_tuser});
    end

    task automatic do_reset();
        aresetn       = 1'b0;
        ch_fire       = '0;
        ch_data       = '0;
        ch_last       = '0;
        ch_enable     = '1;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        q_main.delete();
        q_fix.delete();
    endtask

    task automatic drive_ch(input int ch, input logic [63:0] d, input logic l);
        ch_fire[ch]         = 1'b1;
        ch_data[ch*DW +: DW] = d;
        ch_last[ch]         = l;
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
        ch_fire = '0;
        ch_last = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser});
        end
        n_checks++;
        if ({m_axis_tdata, m_axis_tdest} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%0d required 0/0", m_axis_tdata, m_axis_tdest);
        end
        n_checks++;
        if (drop_count !== '0 || f_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counts: got %h valid_fix=%b required 0/0", drop_count, f_tvalid);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        m_axis_tready = 1'b1;
        drive_ch(CH_R, 64'hA5, 1'b1);
        cycle();
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: tvalid got %b required 0 after one edge", m_axis_tvalid);
        end
        cycle();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tlast, m_axis_tuser} !== {1'b1, 64'hA5, 3'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_beat: got v=%b d=%h dest=%0d l=%b u=%b required v=1 d=a5 dest=2 l=1 u=0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tlast, m_axis_tuser);
        end
        cycle();
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: tvalid got %b required 0", m_axis_tvalid);
        end
    endtask

    task automatic test_rr_all();
        do_reset();
        m_axis_tready = 1'b1;
        for (int c = 0; c < NCH; c++) drive_ch(c, 64'h10 + 64'(c), 1'b1);
        cycle();
        for (int k = 0; k < NCH; k++) begin
            cycle();
            n_checks++;
            if ({m_axis_tvalid, m_axis_tdest, m_axis_tdata} !== {1'b1, 3'(k), 64'h10 + 64'(k)}) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got v=%b dest=%0d d=%h required v=1 dest=%0d d=%h",
                         k, m_axis_tvalid, m_axis_tdest, m_axis_tdata, k, 64'h10 + 64'(k));
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        m_axis_tready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            drive_ch(CH_AW, 64'h100 + 64'(b), 1'b1);
            cycle();
        end
        n_checks++;
        if (drop_count[CH_AW*CW +: CW] !== 16'd1 || drop_count[CH_AR*CW +: CW] !== 16'd0) begin
            n_fail++;
            $display("FAIL ovf_count: got ch1=%0d ch0=%0d required 1/0",
                     drop_count[CH_AW*CW +: CW], drop_count[CH_AR*CW +: CW]);
        end
        m_axis_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser} !== {1'b1, 64'h100 + 64'(k), 1'b0}) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got v=%b d=%h u=%b required v=1 d=%h u=0",
                         k, m_axis_tvalid, m_axis_tdata, m_axis_tuser, 64'h100 + 64'(k));
            end
            cycle();
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_empty: tvalid got %b required 0", m_axis_tvalid);
        end
        drive_ch(CH_AW, 64'h1FF, 1'b1);
        cycle();
        cycle();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser} !== {1'b1, 64'h1FF, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_tuser_set: got v=%b d=%h u=%b required v=1 d=1ff u=1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser);
        end
        drive_ch(CH_AW, 64'h1FE, 1'b1);
        cycle();
        cycle();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser} !== {1'b1, 64'h1FE, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_tuser_clr: got v=%b d=%h u=%b required v=1 d=1fe u=0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser);
        end
    endtask

    task automatic test_pkt_lock();
        logic [2:0]  exp_dest [4] = '{3'd3, 3'd3, 3'd3, 3'd0};
        logic [63:0] exp_data [4] = '{64'h30, 64'h31, 64'h32, 64'h01};
        do_reset();
        m_axis_tready = 1'b1;
        drive_ch(CH_W, 64'h30, 1'b0);
        cycle();
        drive_ch(CH_W, 64'h31, 1'b0);
        drive_ch(CH_AR, 64'h01, 1'b1);
        cycle();
        drive_ch(CH_W, 64'h32, 1'b1);
        cycle();
        repeat (8) cycle();
        n_checks++;
        if (q_main.size() != 4) begin
            n_fail++;
            $display("FAIL lock_count: got %0d beats required 4", q_main.size());
        end
        for (int k = 0; k < 4 && k < q_main.size(); k++) begin
            n_checks++;
            if ({q_main[k].dest, q_main[k].data} !== {exp_dest[k], exp_data[k]} ||
                q_main[k].cyc != q_main[0].cyc + k) begin
                n_fail++;
                $display("FAIL lock_order[%0d]: got dest=%0d d=%h cyc+%0d required dest=%0d d=%h cyc+%0d",
                         k, q_main[k].dest, q_main[k].data, q_main[k].cyc - q_main[0].cyc,
                         exp_dest[k], exp_data[k], k);
            end
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        m_axis_tready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            drive_ch(CH_AW, 64'h40 + 64'(b), 1'b1);
            drive_ch(CH_B,  64'h80 + 64'(b), 1'b1);
            cycle();
        end
        repeat (14) cycle();
        n_checks++;
        if (q_fix.size() != 10) begin
            n_fail++;
            $display("FAIL fix_count: got %0d beats required 10", q_fix.size());
        end
        for (int k = 0; k < 10 && k < q_fix.size(); k++) begin
            logic [2:0]  ed;
            logic [63:0] edata;
            ed    = (k < 6) ? 3'd1 : 3'd4;
            edata = (k < 6) ? 64'h40 + 64'(k) : 64'h80 + 64'(k - 6);
            n_checks++;
            if ({q_fix[k].dest, q_fix[k].data, q_fix[k].user} !== {ed, edata, 1'b0}) begin
                n_fail++;
                $display("FAIL fix_order[%0d]: got dest=%0d d=%h u=%b required dest=%0d d=%h u=0",
                         k, q_fix[k].dest, q_fix[k].data, q_fix[k].user, ed, edata);
            end
        end
        n_checks++;
        if (f_drop_count[CH_B*CW +: CW] !== 16'd2) begin
            n_fail++;
            $display("FAIL fix_drops: got %0d required 2", f_drop_count[CH_B*CW +: CW]);
        end
    endtask

    task automatic test_disable_flush();
        do_reset();
        m_axis_tready = 1'b0;
        drive_ch(CH_R, 64'h50, 1'b0);
        cycle();
        drive_ch(CH_R, 64'h51, 1'b0);
        cycle();
        drive_ch(CH_R, 64'h52, 1'b0);
        drive_ch(CH_AR, 64'h60, 1'b1);
        cycle();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdest, m_axis_tdata} !== {1'b1, 3'd2, 64'h50}) begin
            n_fail++;
            $display("FAIL dis_held: got v=%b dest=%0d d=%h required v=1 dest=2 d=50",
                     m_axis_tvalid, m_axis_tdest, m_axis_tdata);
        end
        ch_enable[CH_R] = 1'b0;
        drive_ch(CH_R, 64'h53, 1'b1);
        cycle();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdest, m_axis_tdata, m_axis_tlast} !== {1'b1, 3'd2, 64'h50, 1'b0}) begin
            n_fail++;
            $display("FAIL dis_stable: got v=%b dest=%0d d=%h l=%b required v=1 dest=2 d=50 l=0",
                     m_axis_tvalid, m_axis_tdest, m_axis_tdata, m_axis_tlast);
        end
        ch_enable[CH_R] = 1'b1;
        m_axis_tready   = 1'b1;
        cycle();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdest, m_axis_tdata, m_axis_tlast} !== {1'b1, 3'd0, 64'h60, 1'b1}) begin
            n_fail++;
            $display("FAIL dis_next: got v=%b dest=%0d d=%h l=%b required v=1 dest=0 d=60 l=1",
                     m_axis_tvalid, m_axis_tdest, m_axis_tdata, m_axis_tlast);
        end
        cycle();
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || drop_count[CH_R*CW +: CW] !== 16'd0) begin
            n_fail++;
            $display("FAIL dis_flushed: got v=%b drops=%0d required v=0 drops=0",
                     m_axis_tvalid, drop_count[CH_R*CW +: CW]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        m_axis_tready = 1'b0;
        for (int b = 0; b < 7; b++) begin
            drive_ch(CH_AW, 64'h200 + 64'(b), 1'b1);
            cycle();
        end
        n_checks++;
        if (drop_count[CH_AW*CW +: CW] !== 16'd2 || m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got drops=%0d v=%b required drops=2 v=1",
                     drop_count[CH_AW*CW +: CW], m_axis_tvalid);
        end
        #3 aresetn = 1'b0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || drop_count !== '0) begin
            n_fail++;
            $display("FAIL areset_now: got v=%b drops=%h required v=0 drops=0", m_axis_tvalid, drop_count);
        end
        @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_rr_all();
        test_overflow();
        test_pkt_lock();
        test_fixed_prio();
        test_disable_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
